// File: rtl/arb_rr_4.sv
// -----------------------------------------------------------------------------
// arb_rr_4 -- four-requester round-robin arbiter
//
// Decides which of four clients owns a shared resource. The grant is
// registered and is presented both as a one-hot vector and as the
// enable/select pair of an external 2-to-4 one-hot decoder. Priority
// rotates past every winner so that no requester starves.
//
// Optional feature (compile-time macro ARB_RR_HOLD_LIMIT_EN):
//   When defined, a grant is force-released after HOLD_MAX consecutive
//   cycles and `preempt` pulses for one cycle. When undefined there is no
//   hold counter, a grant lasts as long as the owner's request, and
//   `preempt` is tied low.
//
// Parameters:
//   HOLD_MAX  maximum consecutive grant cycles with the hold limit (2..255)
//
// Ports:
//   clk      in   system clock, rising-edge active
//   reset_n  in   asynchronous active-low reset
//   req      in   [3:0] level-sensitive request vector, bit i = requester i
//   gnt      out  [3:0] registered one-hot grant, zero when idle
//   gnt_idx  out  [1:0] registered owner index (decoder select)
//   gnt_vld  out  registered grant-active flag (decoder enable)
//   preempt  out  registered one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module arb_rr_4 #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_vld,
    output logic       preempt
);

    // Reject an out-of-range hold limit at elaboration time.
    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("arb_rr_4: HOLD_MAX must be in 2..255");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q,   state_d;
    logic [1:0] ptr_q,     ptr_d;
    logic [3:0] gnt_q,     gnt_d;
    logic [1:0] gnt_idx_q, gnt_idx_d;
    logic       gnt_vld_q, gnt_vld_d;
    logic       preempt_q, preempt_d;
`ifdef ARB_RR_HOLD_LIMIT_EN
    logic [7:0] cnt_q,     cnt_d;
`endif

    // Winner selection: first set request scanning ptr, ptr+1, ptr+2, ptr+3.
    // Iterating from the farthest offset down lets the nearest one win.
    logic [1:0] win;
    always_comb begin
        win = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (req[ptr_q + 2'(i)]) begin
                win = ptr_q + 2'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        gnt_vld_d = gnt_vld_q;
        preempt_d = 1'b0;
`ifdef ARB_RR_HOLD_LIMIT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d     = 4'b0001 << win;
                    gnt_idx_d = win;
                    gnt_vld_d = 1'b1;
                    ptr_d     = win + 2'd1;
`ifdef ARB_RR_HOLD_LIMIT_EN
                    cnt_d     = 8'd1;
`endif
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                if (!req[gnt_idx_q]) begin
                    // Voluntary release; gnt_idx keeps the last owner.
                    gnt_d     = 4'b0000;
                    gnt_vld_d = 1'b0;
                    state_d   = IDLE;
                end
`ifdef ARB_RR_HOLD_LIMIT_EN
                else if (cnt_q == 8'(HOLD_MAX)) begin
                    // Owner still requesting but has used its budget.
                    gnt_d     = 4'b0000;
                    gnt_vld_d = 1'b0;
                    preempt_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d   = IDLE;
                gnt_d     = 4'b0000;
                gnt_vld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ptr_q     <= 2'b00;
            gnt_q     <= 4'b0000;
            gnt_idx_q <= 2'b00;
            gnt_vld_q <= 1'b0;
            preempt_q <= 1'b0;
`ifdef ARB_RR_HOLD_LIMIT_EN
            cnt_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_vld_q <= gnt_vld_d;
            preempt_q <= preempt_d;
`ifdef ARB_RR_HOLD_LIMIT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign gnt_vld = gnt_vld_q;
`ifdef ARB_RR_HOLD_LIMIT_EN
    assign preempt = preempt_q;
`else
    assign preempt = 1'b0;
`endif

`ifndef ARB_RR_HOLD_LIMIT_EN
    // preempt_q only exists to keep both builds structurally alike.
    logic unused_preempt;
    assign unused_preempt = preempt_q;
`endif

endmodule

// File: tb/tb_arb_rr_4.sv
// -----------------------------------------------------------------------------
// tb_arb_rr_4 -- directed self-checking bench for arb_rr_4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_arb_rr_4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_vld;
    logic       preempt;

    int n_cmp = 0;
    int n_err = 0;

    arb_rr_4 #(.HOLD_MAX(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = 4'b0000;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req     = 4'b1111;
        step();
        step();
        n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        n_cmp++; if (gnt_idx !== 2'b00) begin n_err++; $display("FAIL reset_idx: got %0d expected 0", gnt_idx); end
        n_cmp++; if (gnt_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b expected 0", gnt_vld); end
        n_cmp++; if (preempt !== 1'b0) begin n_err++; $display("FAIL reset_preempt: got %b expected 0", preempt); end
        $display("test_reset: gnt=%b idx=%0d vld=%b", gnt, gnt_idx, gnt_vld);
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        step();
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL single_gnt[%0d]: got %b expected 0100", k, gnt); end
            n_cmp++; if (gnt_idx !== 2'd2) begin n_err++; $display("FAIL single_idx[%0d]: got %0d expected 2", k, gnt_idx); end
            n_cmp++; if (gnt_vld !== 1'b1) begin n_err++; $display("FAIL single_vld[%0d]: got %b expected 1", k, gnt_vld); end
            step();
        end
        req = 4'b0000;
        step();
        n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL release_gnt: got %b expected 0000", gnt); end
        n_cmp++; if (gnt_vld !== 1'b0) begin n_err++; $display("FAIL release_vld: got %b expected 0", gnt_vld); end
        n_cmp++; if (gnt_idx !== 2'd2) begin n_err++; $display("FAIL release_idx: got %0d expected 2", gnt_idx); end
        $display("test_single: released gnt=%b idx=%0d", gnt, gnt_idx);
    endtask

    task automatic test_rotation();
        logic [1:0] exp_idx [5];
        exp_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        req = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (gnt !== (4'b0001 << exp_idx[k])) begin n_err++; $display("FAIL rot_gnt[%0d]: got %b expected idx %0d", k, gnt, exp_idx[k]); end
            n_cmp++; if (gnt_idx !== exp_idx[k]) begin n_err++; $display("FAIL rot_idx[%0d]: got %0d expected %0d", k, gnt_idx, exp_idx[k]); end
            $display("test_rotation: grant %0d gnt=%b", k, gnt);
            req = 4'b1111 & ~(4'b0001 << exp_idx[k]);
            step();
            n_cmp++; if (gnt_vld !== 1'b0) begin n_err++; $display("FAIL rot_idle[%0d]: got vld %b expected 0", k, gnt_vld); end
            req = 4'b1111;
            step();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req = 4'b1000;
        step();
        n_cmp++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL wrap_first: got %b expected 1000", gnt); end
        req = 4'b0000;
        step();
        req = 4'b1001;
        step();
        n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL wrap_next: got %b expected 0001", gnt); end
        n_cmp++; if (gnt_idx !== 2'd0) begin n_err++; $display("FAIL wrap_idx: got %0d expected 0", gnt_idx); end
        $display("test_wrap: gnt=%b", gnt);
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0010;
        step();
        n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL ares_pre: got %b expected 0010", gnt); end
        step();
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL ares_gnt: got %b expected 0000", gnt); end
        n_cmp++; if (gnt_vld !== 1'b0) begin n_err++; $display("FAIL ares_vld: got %b expected 0", gnt_vld); end
        n_cmp++; if (preempt !== 1'b0) begin n_err++; $display("FAIL ares_preempt: got %b expected 0", preempt); end
        req = 4'b0011;
        #1;
        reset_n = 1'b1;
        step();
        n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL ares_after: got %b expected 0001", gnt); end
        $display("test_async_reset: after release gnt=%b", gnt);
    endtask

    task automatic test_hold();
        do_reset();
        req = 4'b0011;
        step();
`ifdef ARB_RR_HOLD_LIMIT_EN
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL hold_gnt[%0d]: got %b expected 0001", k, gnt); end
            n_cmp++; if (preempt !== 1'b0) begin n_err++; $display("FAIL hold_pre[%0d]: got %b expected 0", k, preempt); end
            step();
        end
        n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL hold_idle: got %b expected 0000", gnt); end
        n_cmp++; if (preempt !== 1'b1) begin n_err++; $display("FAIL hold_pulse: got %b expected 1", preempt); end
        step();
        n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL hold_next: got %b expected 0010", gnt); end
        n_cmp++; if (preempt !== 1'b0) begin n_err++; $display("FAIL hold_pulse_end: got %b expected 0", preempt); end
`else
        for (int k = 0; k < 100; k++) begin
            n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL hold_gnt[%0d]: got %b expected 0001", k, gnt); end
            n_cmp++; if (preempt !== 1'b0) begin n_err++; $display("FAIL hold_pre[%0d]: got %b expected 0", k, preempt); end
            step();
        end
`endif
        $display("test_hold: gnt=%b preempt=%b", gnt, preempt);
    endtask

    task automatic test_random();
        logic       prev_vld;
        logic [3:0] waiting;
        int         foreign [4];
        int         grants;
        do_reset();
        prev_vld = 1'b0;
        waiting  = 4'b0000;
        grants   = 0;
        for (int i = 0; i < 4; i++) foreign[i] = 0;
        req = 4'($urandom_range(0, 15));
        for (int c = 0; c < 10000; c++) begin
            step();
            n_cmp++;
            if ((gnt & (gnt - 4'd1)) !== 4'b0000 || gnt_vld !== (|gnt) ||
                gnt !== (gnt_vld ? (4'b0001 << gnt_idx) : 4'b0000)) begin
                n_err++;
                $display("FAIL rand_invariant[%0d]: got gnt=%b vld=%b idx=%0d", c, gnt, gnt_vld, gnt_idx);
            end
`ifndef ARB_RR_HOLD_LIMIT_EN
            n_cmp++; if (preempt !== 1'b0) begin n_err++; $display("FAIL rand_preempt[%0d]: got %b expected 0", c, preempt); end
`endif
            if (gnt_vld && !prev_vld) begin
                grants++;
                for (int i = 0; i < 4; i++) begin
                    if (waiting[i] && gnt_idx != 2'(i)) begin
                        foreign[i]++;
                        n_cmp++;
                        if (foreign[i] > 3) begin
                            n_err++;
                            $display("FAIL rand_starve[%0d]: requester %0d saw %0d foreign grants, limit 3", c, i, foreign[i]);
                        end
                    end
                end
            end
            prev_vld = gnt_vld;
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
            end
            for (int i = 0; i < 4; i++) begin
                if (!req[i] || (gnt_vld && gnt_idx == 2'(i))) begin
                    waiting[i] = 1'b0;
                    foreign[i] = 0;
                end else if (!waiting[i]) begin
                    waiting[i] = 1'b1;
                    foreign[i] = 0;
                end
            end
        end
        n_cmp++; if (grants < 100) begin n_err++; $display("FAIL rand_activity: got %0d grants expected at least 100", grants); end
        $display("test_random: %0d grants observed", grants);
    endtask

    initial begin
        reset_n = 1'b0;
        req     = 4'b0000;
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_async_reset();
        test_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
